// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the unified memory port arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF        = 64;
    localparam int DATA_W_DEF        = 64;
    localparam int INST_W_DEF        = 32;
    localparam int MAX_DM_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-ported memory bus: valid/ready request, rvalid response
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output valid, we, addr, wdata, be,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, be,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - combinational owner choice; DM first unless the fairness force is raised
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_if_flush,
    input  logic       i_dm_req,
    input  logic       i_force_if,
    output arb_owner_t o_owner
);

    logic w_if_ok;

    assign w_if_ok = i_if_req && !i_if_flush;

    always_comb begin
        o_owner = OWN_NONE;
        if (w_if_ok && i_force_if) begin
            o_owner = OWN_IF;
        end else if (i_dm_req) begin
            o_owner = OWN_DM;
        end else if (w_if_ok) begin
            o_owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter in front of one unified memory port
// Optional DM-streak fairness limit is compiled in with ARB_FAIR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int INST_W        = INST_W_DEF,
    parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
)
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [INST_W-1:0]   o_if_rdata,
    output logic                o_if_stall,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_dm_stall,
    mem_port_arbiter_if.master  mem_bus
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_owner_t          r_owner;
    arb_owner_t          w_sel;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_if_a2;
    logic                r_if_drop;
    logic                w_force_if;
    logic                w_if_gnt;
    logic                w_dm_gnt;
    logic                w_if_rvalid;
    logic                w_dm_rvalid;

    mem_arb_select u_select (
        .i_if_req   (i_if_req),
        .i_if_flush (i_if_flush),
        .i_dm_req   (i_dm_req),
        .i_force_if (w_force_if),
        .o_owner    (w_sel)
    );

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    logic [STREAK_W-1:0] r_dm_streak;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dm_streak <= '0;
        end else if (w_if_gnt || !i_dm_req) begin
            r_dm_streak <= '0;
        end else if (w_dm_gnt && (r_dm_streak != STREAK_W'(MAX_DM_STREAK))) begin
            r_dm_streak <= r_dm_streak + 1'b1;
        end
    end

    assign w_force_if = (r_dm_streak == STREAK_W'(MAX_DM_STREAK));
    logic w_unused_bits;
    assign w_unused_bits = ^{i_if_addr[1:0], i_dm_addr[2:0]};
`else
    assign w_force_if = 1'b0;
    logic w_unused_bits;
    assign w_unused_bits = ^{i_if_addr[1:0], i_dm_addr[2:0], MAX_DM_STREAK[0]};
`endif

    // Handshake outputs are combinational so a same-cycle ready/rvalid is reported without delay.
    assign w_if_gnt    = !i_reset && (r_state == ISSUE) && (r_owner == OWN_IF) && mem_bus.ready;
    assign w_dm_gnt    = !i_reset && (r_state == ISSUE) && (r_owner == OWN_DM) && mem_bus.ready;
    assign w_if_rvalid = !i_reset && (r_state == WAIT) && (r_owner == OWN_IF) && mem_bus.rvalid
                         && !r_if_drop && !i_if_flush;
    assign w_dm_rvalid = !i_reset && (r_state == WAIT) && (r_owner == OWN_DM) && mem_bus.rvalid;

    assign o_if_gnt    = w_if_gnt;
    assign o_dm_gnt    = w_dm_gnt;
    assign o_if_rvalid = w_if_rvalid;
    assign o_dm_rvalid = w_dm_rvalid;
    assign o_if_rdata  = !w_if_rvalid ? '0 :
                         (r_if_a2 ? mem_bus.rdata[2*INST_W-1:INST_W] : mem_bus.rdata[INST_W-1:0]);
    assign o_dm_rdata  = w_dm_rvalid ? mem_bus.rdata : '0;
    assign o_if_stall  = !i_reset && i_if_req && !w_if_rvalid;
    assign o_dm_stall  = !i_reset && i_dm_req && !w_dm_rvalid;

    assign mem_bus.valid = !i_reset && (r_state == ISSUE);
    assign mem_bus.we    = r_we;
    assign mem_bus.addr  = r_addr;
    assign mem_bus.wdata = r_wdata;
    assign mem_bus.be    = r_be;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_NONE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_if_a2   <= 1'b0;
            r_if_drop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel != OWN_NONE) begin
                        r_owner   <= w_sel;
                        r_state   <= ISSUE;
                        r_if_drop <= 1'b0;
                        if (w_sel == OWN_DM) begin
                            r_we    <= i_dm_we;
                            r_addr  <= {i_dm_addr[ADDR_W-1:3], 3'b000};
                            r_wdata <= i_dm_wdata;
                            r_be    <= i_dm_we ? i_dm_be : '1;
                            r_if_a2 <= 1'b0;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= {i_if_addr[ADDR_W-1:3], 3'b000};
                            r_wdata <= '0;
                            r_be    <= '1;
                            r_if_a2 <= i_if_addr[2];
                        end
                    end
                end
                ISSUE: begin
                    // A flushed fetch still has to finish on the bus; only its response is dropped.
                    if ((r_owner == OWN_IF) && i_if_flush) begin
                        r_if_drop <= 1'b1;
                    end
                    if (mem_bus.ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if ((r_owner == OWN_IF) && i_if_flush) begin
                        r_if_drop <= 1'b1;
                    end
                    if (mem_bus.rvalid) begin
                        r_state <= IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid, if_stall;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic [7:0]  dm_be;
    logic        dm_gnt, dm_rvalid, dm_stall;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mem_bus ();

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .i_if_flush  (if_flush),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .o_if_stall  (if_stall),
        .i_dm_req    (dm_req),
        .i_dm_we     (dm_we),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .i_dm_be     (dm_be),
        .o_dm_gnt    (dm_gnt),
        .o_dm_rvalid (dm_rvalid),
        .o_dm_rdata  (dm_rdata),
        .o_dm_stall  (dm_stall),
        .mem_bus     (mem_bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_bus.ready = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
        tick(); tick();
        settle();
        chk("rst_mem_valid", mem_bus.valid, 0);
        chk("rst_if_stall", if_stall, 0);
        chk("rst_dm_rvalid", dm_rvalid, 0);
        tick();
        rst = 1'b0;

        // IF only: 0x1004 returns the upper half of the word on cycle 2
        tick();
        if_req = 1'b1; if_addr = 64'h1004;
        settle();
        chk("t1_c0_mem_valid", mem_bus.valid, 0);
        chk("t1_c0_if_stall", if_stall, 1);
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t1_c1_mem_valid", mem_bus.valid, 1);
        chk("t1_c1_mem_addr", mem_bus.addr, 64'h1000);
        chk("t1_c1_mem_be", mem_bus.be, 8'hFF);
        chk("t1_c1_if_gnt", if_gnt, 1);
        tick();
        mem_bus.ready = 1'b0; if_req = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'hAAAA_BBBB_1111_2222;
        settle();
        chk("t1_c2_if_rvalid", if_rvalid, 1);
        chk("t1_c2_if_rdata", if_rdata, 32'hAAAABBBB);
        chk("t1_c2_dm_rvalid", dm_rvalid, 0);
        tick();
        mem_bus.rvalid = 1'b0;

        // IF and DM together: DM load wins, IF waits for the DM response
        tick();
        if_req = 1'b1; if_addr = 64'h1008;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000;
        settle();
        chk("t2_idle_if_stall", if_stall, 1);
        chk("t2_idle_dm_stall", dm_stall, 1);
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t2_dm_gnt", dm_gnt, 1);
        chk("t2_if_gnt_blocked", if_gnt, 0);
        chk("t2_dm_mem_addr", mem_bus.addr, 64'h2000);
        chk("t2_issue_if_stall", if_stall, 1);
        tick();
        mem_bus.ready = 1'b0; dm_req = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h0123_4567_89AB_CDEF;
        settle();
        chk("t2_dm_rvalid", dm_rvalid, 1);
        chk("t2_dm_rdata", dm_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t2_wait_if_rvalid", if_rvalid, 0);
        chk("t2_wait_if_stall", if_stall, 1);
        tick();
        mem_bus.rvalid = 1'b0;
        settle();
        chk("t2_idle2_mem_valid", mem_bus.valid, 0);
        chk("t2_idle2_if_stall", if_stall, 1);
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t2_if_gnt", if_gnt, 1);
        chk("t2_if_mem_addr", mem_bus.addr, 64'h1008);
        tick();
        mem_bus.ready = 1'b0; if_req = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h1234_5678_9ABC_DEF0;
        settle();
        chk("t2_if_rvalid", if_rvalid, 1);
        chk("t2_if_rdata", if_rdata, 32'h9ABCDEF0);
        tick();
        mem_bus.rvalid = 1'b0;

        // Store with partial byte enables
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h3008; dm_wdata = 64'h55; dm_be = 8'h0F;
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t3_mem_we", mem_bus.we, 1);
        chk("t3_mem_addr", mem_bus.addr, 64'h3008);
        chk("t3_mem_be", mem_bus.be, 8'h0F);
        chk("t3_mem_wdata", mem_bus.wdata, 64'h55);
        chk("t3_dm_gnt", dm_gnt, 1);
        chk("t3_if_gnt", if_gnt, 0);
        tick();
        mem_bus.ready = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = '0;
        settle();
        chk("t3_dm_ack", dm_rvalid, 1);
        chk("t3_if_rvalid", if_rvalid, 0);
        tick();
        mem_bus.rvalid = 1'b0;

        // Memory holds off ready for 5 cycles: request stays stable, one grant
        tick();
        dm_req = 1'b1; dm_addr = 64'h500F;
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk($sformatf("t4_hold%0d_valid", i), mem_bus.valid, 1);
            chk($sformatf("t4_hold%0d_addr", i), mem_bus.addr, 64'h5008);
            chk($sformatf("t4_hold%0d_be", i), mem_bus.be, 8'hFF);
            chk($sformatf("t4_hold%0d_gnt", i), dm_gnt, 0);
        end
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t4_gnt", dm_gnt, 1);
        tick();
        mem_bus.ready = 1'b0; dm_req = 1'b0;
        settle();
        chk("t4_wait_gnt", dm_gnt, 0);
        chk("t4_wait_valid", mem_bus.valid, 0);
        tick();
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'hFEED_0000_0000_BEEF;
        settle();
        chk("t4_rdata", dm_rdata, 64'hFEED_0000_0000_BEEF);
        tick();
        mem_bus.rvalid = 1'b0;

        // Flush during WAIT drops the response; flush in IDLE blocks selection
        tick();
        if_req = 1'b1; if_addr = 64'h1100;
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t5_gnt", if_gnt, 1);
        tick();
        mem_bus.ready = 1'b0; if_req = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h1111_1111_2222_2222;
        settle();
        chk("t5_flushed_rvalid", if_rvalid, 0);
        tick();
        mem_bus.rvalid = 1'b0;
        if_req = 1'b1; if_addr = 64'h4000; if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        settle();
        chk("t5_idle_flush_block", mem_bus.valid, 0);
        tick();
        mem_bus.ready = 1'b1;
        settle();
        chk("t5_next_addr", mem_bus.addr, 64'h4000);
        chk("t5_next_gnt", if_gnt, 1);
        tick();
        mem_bus.ready = 1'b0; if_req = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'hDEAD_BEEF_CAFE_F00D;
        settle();
        chk("t5_next_rvalid", if_rvalid, 1);
        chk("t5_next_rdata", if_rdata, 32'hCAFEF00D);
        tick();
        mem_bus.rvalid = 1'b0;

        // Reset while waiting, then a late response must be ignored
        tick();
        dm_req = 1'b1; dm_addr = 64'h6000;
        tick();
        mem_bus.ready = 1'b1;
        tick();
        mem_bus.ready = 1'b0; dm_req = 1'b0; rst = 1'b1;
        settle();
        chk("t6_rst_mem_valid", mem_bus.valid, 0);
        chk("t6_rst_dm_rvalid", dm_rvalid, 0);
        tick();
        rst = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'h7777;
        settle();
        chk("t6_late_dm_rvalid", dm_rvalid, 0);
        chk("t6_late_if_rvalid", if_rvalid, 0);
        chk("t6_late_mem_valid", mem_bus.valid, 0);
        tick();
        mem_bus.rvalid = 1'b0;

        // Back-to-back DM with IF pending: slot 5 goes to IF only with fairness enabled
        tick();
        if_req = 1'b1; if_addr = 64'h7000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h8000;
        for (int k = 0; k < 5; k++) begin
            tick();
            mem_bus.ready = 1'b1;
            settle();
            chk($sformatf("t7_slot%0d_dm_gnt", k), dm_gnt, (k == 4 && FAIR) ? 0 : 1);
            chk($sformatf("t7_slot%0d_if_gnt", k), if_gnt, (k == 4 && FAIR) ? 1 : 0);
            tick();
            mem_bus.ready = 1'b0;
            mem_bus.rvalid = 1'b1;
            dm_addr = dm_addr + 64'h8;
            tick();
            mem_bus.rvalid = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
